// File: rtl/axi2apb_cmd_burst.sv
// AXI AW/AR command arbiter, command FIFO and burst expander feeding an APB master FSM.
// Each presented beat is one 32-bit APB access with its own address, ID, last and error flag.
module axi2apb_cmd_burst #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int SEL_WIDTH      = 4,
    parameter int LEN_WIDTH      = 8,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [AXI_ID_WIDTH-1:0]             AWID,
    input  logic [AXI_ADDR_WIDTH-1:0]           AWADDR,
    input  logic [LEN_WIDTH-1:0]                AWLEN,
    input  logic [2:0]                          AWSIZE,
    input  logic [1:0]                          AWBURST,
    input  logic                                AWVALID,
    output logic                                AWREADY,
    input  logic [AXI_ID_WIDTH-1:0]             ARID,
    input  logic [AXI_ADDR_WIDTH-1:0]           ARADDR,
    input  logic [LEN_WIDTH-1:0]                ARLEN,
    input  logic [2:0]                          ARSIZE,
    input  logic [1:0]                          ARBURST,
    input  logic                                ARVALID,
    output logic                                ARREADY,
    input  logic                                finish_wr,
    input  logic                                finish_rd,
    output logic                                cmd_empty,
    output logic                                cmd_read,
    output logic [AXI_ID_WIDTH-1:0]             cmd_id,
    output logic [SEL_WIDTH+APB_ADDR_WIDTH-1:0] cmd_addr,
    output logic [LEN_WIDTH-1:0]                cmd_len,
    output logic                                cmd_last,
    output logic                                cmd_err
);

    localparam int CMD_AW = SEL_WIDTH + APB_ADDR_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [CMD_AW-1:0]       addr;
        logic [LEN_WIDTH-1:0]    len;
        logic                    err;
        logic                    read;
        logic                    incr;
    } cmd_t;

    cmd_t                mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                sel_rd;
    logic [LEN_WIDTH-1:0]      beat;
    logic [APB_ADDR_WIDTH-1:0] off;

    logic full;
    logic empty;
    logic ar_hs;
    logic aw_hs;
    logic push;
    logic pop;
    logic retire;
    logic last;
    cmd_t head;
    cmd_t push_cmd;
    logic [2:0] push_size;
    logic [1:0] push_burst;
    logic       unused_addr_bits;

    // Upper AXI address bits above the select field do not reach the APB side.
    assign unused_addr_bits = ^{AWADDR, ARADDR};

    // Handshake: a channel transfers on a cycle where VALID and READY are both
    // high at the rising edge; READY depends only on registered full and sel_rd.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign ARREADY = ~full & sel_rd;
    assign AWREADY = ~full & ~sel_rd;
    assign ar_hs   = ARVALID & ARREADY;
    assign aw_hs   = AWVALID & AWREADY;
    assign push    = ar_hs | aw_hs;

    always_comb begin
        push_cmd   = '0;
        push_size  = sel_rd ? ARSIZE  : AWSIZE;
        push_burst = sel_rd ? ARBURST : AWBURST;
        push_cmd.read = sel_rd;
        push_cmd.id   = sel_rd ? ARID : AWID;
        push_cmd.addr = sel_rd ? ARADDR[CMD_AW-1:0] : AWADDR[CMD_AW-1:0];
        push_cmd.len  = sel_rd ? ARLEN : AWLEN;
        push_cmd.err  = (push_size != 3'd2) | push_burst[1];
        push_cmd.incr = (push_burst == 2'b01) & ~push_cmd.err;
    end

    assign head   = mem[rd_ptr];
    assign last   = (beat == head.len);
    assign retire = ~empty & (head.read ? finish_rd : finish_wr);
    assign pop    = retire & last;

    assign cmd_empty = empty;
    assign cmd_read  = ~empty & head.read;
    assign cmd_id    = empty ? '0 : head.id;
    assign cmd_addr  = empty ? '0 :
                       {head.addr[CMD_AW-1:APB_ADDR_WIDTH], head.addr[APB_ADDR_WIDTH-1:0] + off};
    assign cmd_len   = empty ? '0 : head.len;
    assign cmd_last  = ~empty & last;
    assign cmd_err   = ~empty & head.err;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_rd <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            beat   <= '0;
            off    <= '0;
        end else begin
            // Whichever channel was just served (or is idle) yields to the other.
            if (AWVALID & (ar_hs | ~ARVALID)) begin
                sel_rd <= 1'b0;
            end else if (ARVALID & (aw_hs | ~AWVALID)) begin
                sel_rd <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (retire) begin
                if (last) begin
                    beat <= '0;
                    off  <= '0;
                end else begin
                    beat <= beat + LEN_WIDTH'(1);
                    if (head.incr) begin
                        off <= off + APB_ADDR_WIDTH'(4);
                    end
                end
            end
        end
    end

endmodule
